// File: rtl/div_param.sv
// div_param: parametrised sequential restoring divider, signed/unsigned, one quotient bit per cycle.
module div_param #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             comenzar,
  input  logic             con_signo,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  output logic             ocupado,
  output logic             finalizado,
  output logic [WIDTH-1:0] cociente,
  output logic [WIDTH-1:0] residuo,
  output logic             div_cero,
  output logic             desbordamiento
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [2:0] {REPOSO, CARGAR, ITERAR, CORREGIR, TERMINADO} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_dvd, r_dvs, r_mdvs, r_q, r_rem;
  logic r_signed, r_qs, r_rs;
  logic [CW-1:0] r_cnt;
  logic [WIDTH:0] w_sh, w_trial;
  logic [WIDTH-1:0] w_mdvd, w_mdvs;
  logic w_dvd_neg, w_dvs_neg, w_ovf;

  assign ocupado   = r_state != REPOSO;
  assign w_dvd_neg = r_signed & r_dvd[WIDTH-1];
  assign w_dvs_neg = r_signed & r_dvs[WIDTH-1];
  assign w_mdvd    = w_dvd_neg ? -r_dvd : r_dvd;
  assign w_mdvs    = w_dvs_neg ? -r_dvs : r_dvs;
  // The remainder never exceeds the divisor, so WIDTH+1 bits hold the trial sign exactly.
  assign w_sh      = {r_rem, r_q[WIDTH-1]};
  assign w_trial   = w_sh - {1'b0, r_mdvs};
  assign w_ovf     = r_signed && r_dvd == {1'b1, {(WIDTH-1){1'b0}}} && &r_dvs;

  always_comb begin
    w_next = REPOSO;
    case (r_state)
      REPOSO:   w_next = comenzar ? CARGAR : REPOSO;
      CARGAR:   w_next = r_dvs == '0 ? TERMINADO : ITERAR;
      ITERAR:   w_next = r_cnt == CW'(1) ? CORREGIR : ITERAR;
      CORREGIR: w_next = TERMINADO;
      default:  w_next = REPOSO;
    endcase
  end

  always_ff @(posedge clock) r_state <= rst ? REPOSO : w_next;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_dvd          <= '0;
      r_dvs          <= '0;
      r_mdvs         <= '0;
      r_q            <= '0;
      r_rem          <= '0;
      r_signed       <= 1'b0;
      r_qs           <= 1'b0;
      r_rs           <= 1'b0;
      r_cnt          <= '0;
      cociente       <= '0;
      residuo        <= '0;
      div_cero       <= 1'b0;
      desbordamiento <= 1'b0;
      finalizado     <= 1'b0;
    end else begin
      finalizado <= 1'b0;
      case (r_state)
        REPOSO: if (comenzar) begin
          r_dvd    <= dividendo;
          r_dvs    <= divisor;
          r_signed <= con_signo;
        end
        CARGAR: begin
          r_rem  <= '0;
          r_q    <= w_mdvd;
          r_mdvs <= w_mdvs;
          r_qs   <= w_dvd_neg ^ w_dvs_neg;
          r_rs   <= w_dvd_neg;
          r_cnt  <= CW'(WIDTH);
          if (r_dvs == '0) begin
            cociente       <= '1;
            residuo        <= r_dvd;
            div_cero       <= 1'b1;
            desbordamiento <= 1'b0;
            finalizado     <= 1'b1;
          end
        end
        ITERAR: begin
          r_rem <= w_trial[WIDTH] ? w_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
          r_cnt <= r_cnt - CW'(1);
        end
        CORREGIR: begin
          cociente       <= r_qs ? -r_q : r_q;
          residuo        <= r_rs ? -r_rem : r_rem;
          div_cero       <= 1'b0;
          desbordamiento <= w_ovf;
          finalizado     <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_param.sv
// tb_div_param: random and directed checks of div_param at WIDTH 8/16/32 against an arithmetic model.
module tb_div_param;
  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
  } res_t;

  logic clk = 0;
  logic rst, con_signo, chk_en = 0;
  logic [2:0] start;
  logic [31:0] da, db;
  logic [7:0] q8, r8;
  logic [15:0] q16, r16;
  logic [31:0] q32, r32;
  logic [2:0] busy_w, fin_w, dz_w, ov_w;
  logic [31:0] q_w[3], r_w[3];
  int total = 0, pass = 0;
  int m_t[3], m_lat[3];
  res_t m_p[3], m_o[3];
  logic m_fin[3];

  always #5 clk = ~clk;

  div_param #(.WIDTH(8)) u8 (.clock(clk), .rst(rst), .comenzar(start[0]), .con_signo(con_signo),
    .dividendo(da[7:0]), .divisor(db[7:0]), .ocupado(busy_w[0]), .finalizado(fin_w[0]),
    .cociente(q8), .residuo(r8), .div_cero(dz_w[0]), .desbordamiento(ov_w[0]));
  div_param #(.WIDTH(16)) u16 (.clock(clk), .rst(rst), .comenzar(start[1]), .con_signo(con_signo),
    .dividendo(da[15:0]), .divisor(db[15:0]), .ocupado(busy_w[1]), .finalizado(fin_w[1]),
    .cociente(q16), .residuo(r16), .div_cero(dz_w[1]), .desbordamiento(ov_w[1]));
  div_param #(.WIDTH(32)) u32 (.clock(clk), .rst(rst), .comenzar(start[2]), .con_signo(con_signo),
    .dividendo(da), .divisor(db), .ocupado(busy_w[2]), .finalizado(fin_w[2]),
    .cociente(q32), .residuo(r32), .div_cero(dz_w[2]), .desbordamiento(ov_w[2]));

  assign q_w[0] = {24'd0, q8};
  assign r_w[0] = {24'd0, r8};
  assign q_w[1] = {16'd0, q16};
  assign r_w[1] = {16'd0, r16};
  assign q_w[2] = q32;
  assign r_w[2] = r32;

  function automatic int wid(int i);
    return i == 0 ? 8 : i == 1 ? 16 : 32;
  endfunction

  function automatic res_t ref_div(int w, logic s, logic [31:0] a, logic [31:0] b);
    res_t res;
    longint one = 1;
    longint mask = (one << w) - 1;
    longint ua = longint'(a) & mask;
    longint ub = longint'(b) & mask;
    longint sa = ((ua >> (w - 1)) & 1) != 0 ? ua - (one << w) : ua;
    longint sb = ((ub >> (w - 1)) & 1) != 0 ? ub - (one << w) : ub;
    res = '0;
    if (ub == 0) begin
      res.q = 32'(mask);
      res.r = 32'(ua);
      res.dz = 1'b1;
    end else if (!s) begin
      res.q = 32'(ua / ub);
      res.r = 32'(ua % ub);
    end else if (sa == -(one << (w - 1)) && sb == -1) begin
      res.q = 32'(one << (w - 1));
      res.ov = 1'b1;
    end else begin
      res.q = 32'((sa / sb) & mask);
      res.r = 32'((sa % sb) & mask);
    end
    return res;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_t[i]   <= 0;
        m_o[i]   <= '0;
        m_fin[i] <= 1'b0;
      end else if (m_t[i] == 0) begin
        m_fin[i] <= 1'b0;
        if (start[i]) begin
          m_p[i]   <= ref_div(wid(i), con_signo, da, db);
          m_lat[i] <= ref_div(wid(i), con_signo, da, db).dz ? 1 : wid(i) + 2;
          m_t[i]   <= 1;
        end
      end else begin
        m_fin[i] <= m_t[i] == m_lat[i];
        if (m_t[i] == m_lat[i]) m_o[i] <= m_p[i];
        m_t[i] <= m_t[i] == m_lat[i] + 1 ? 0 : m_t[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("w%0d ocupado", wid(i)), 32'(busy_w[i]), 32'(m_t[i] != 0));
        chk($sformatf("w%0d finalizado", wid(i)), 32'(fin_w[i]), 32'(m_fin[i]));
        chk($sformatf("w%0d cociente", wid(i)), q_w[i], m_o[i].q);
        chk($sformatf("w%0d residuo", wid(i)), r_w[i], m_o[i].r);
        chk($sformatf("w%0d div_cero", wid(i)), 32'(dz_w[i]), 32'(m_o[i].dz));
        chk($sformatf("w%0d desbordamiento", wid(i)), 32'(ov_w[i]), 32'(m_o[i].ov));
      end
    end
  end

  task automatic run(int i, logic s, logic [31:0] a, logic [31:0] b, logic lit,
                     logic [31:0] eq, logic [31:0] er, logic edz, logic eov, int elat, int poke);
    int n;
    @(negedge clk);
    con_signo = s;
    da = a;
    db = b;
    start[i] = 1'b1;
    @(posedge clk);
    #1;
    start[i] = 1'b0;
    da = $urandom;
    db = $urandom;
    con_signo = 1'($urandom);
    n = 0;
    while (n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (fin_w[i]) break;
      start[i] = poke != 0 && n == poke;
    end
    start[i] = 1'b0;
    if (n >= 60) chk($sformatf("w%0d done before timeout", wid(i)), 32'(fin_w[i]), 32'd1);
    if (lit) begin
      chk($sformatf("w%0d latency", wid(i)), 32'(n), 32'(elat));
      chk($sformatf("w%0d lit cociente", wid(i)), q_w[i], eq);
      chk($sformatf("w%0d lit residuo", wid(i)), r_w[i], er);
      chk($sformatf("w%0d lit div_cero", wid(i)), 32'(dz_w[i]), 32'(edz));
      chk($sformatf("w%0d lit desbordamiento", wid(i)), 32'(ov_w[i]), 32'(eov));
    end
    @(negedge clk);
    if (lit) chk($sformatf("w%0d finalizado one cycle", wid(i)), 32'(fin_w[i]), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = '0;
    con_signo = 1'b0;
    da = '0;
    db = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset cociente", q_w[1], 32'd0);
    chk("reset ocupado", 32'(busy_w[1]), 32'd0);
    run(1, 0, 100, 7, 1, 14, 2, 0, 0, 18, 0);
    run(1, 1, 32'hFF9C, 7, 1, 32'hFFF2, 32'hFFFE, 0, 0, 18, 0);
    run(1, 1, 100, 32'hFFF9, 1, 32'hFFF2, 2, 0, 0, 18, 0);
    run(1, 0, 32'hFFFF, 1, 1, 32'hFFFF, 0, 0, 0, 18, 0);
    run(1, 0, 3, 5, 1, 0, 3, 0, 0, 18, 0);
    run(1, 1, 32'hFFFF, 1, 1, 32'hFFFF, 0, 0, 0, 18, 0);
    run(1, 0, 1234, 0, 1, 32'hFFFF, 32'h04D2, 1, 0, 1, 0);
    run(1, 0, 10, 3, 1, 3, 1, 0, 0, 18, 0);
    run(1, 1, 32'h8000, 32'hFFFF, 1, 32'h8000, 0, 0, 1, 18, 0);
    run(1, 1, 32'h8000, 2, 1, 32'hC000, 0, 0, 0, 18, 0);
    run(1, 0, 100, 7, 1, 14, 2, 0, 0, 18, 5);
    @(negedge clk);
    con_signo = 1'b0;
    da = 100;
    db = 7;
    start[1] = 1'b1;
    @(posedge clk);
    #1;
    start[1] = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    start[1] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start[1] = 1'b0;
    chk("abort cociente", q_w[1], 32'd0);
    chk("abort residuo", r_w[1], 32'd0);
    chk("abort ocupado", 32'(busy_w[1]), 32'd0);
    chk("abort flags", {30'd0, dz_w[1], ov_w[1]}, 32'd0);
    repeat (25) begin
      @(negedge clk);
      chk("abort no finalizado", 32'(fin_w[1]), 32'd0);
    end
    run(1, 0, 50, 5, 1, 10, 0, 0, 0, 18, 0);
    run(0, 0, 100, 7, 1, 14, 2, 0, 0, 10, 0);
    run(2, 0, 100, 7, 1, 14, 2, 0, 0, 34, 0);
    run(0, 1, 32'h80, 32'hFF, 1, 32'h80, 0, 0, 1, 10, 0);
    for (int k = 0; k < 150; k++) begin
      int i = $urandom_range(0, 2);
      int mode = $urandom_range(0, 9);
      logic s = 1'($urandom);
      logic [31:0] a = $urandom;
      logic [31:0] b = $urandom;
      if (mode == 0) b = 0;
      if (mode == 1) begin
        s = 1'b1;
        a = 32'd1 << (wid(i) - 1);
        b = 32'hFFFF_FFFF;
      end
      if (mode == 2) b = $urandom_range(1, 15);
      if (mode == 3) b = {$urandom} | 32'hFFFF_FFF0;
      run(i, s, a, b, 0, 0, 0, 0, 0, 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/div_param.md
# div_param

Parametrised sequential restoring divider, the next-generation replacement for the fixed 16-bit calculator divider. It adds a configurable operand width, a signed/unsigned mode, a remainder output, divide-by-zero and signed-overflow flags, and a busy indicator. One quotient bit is produced per clock cycle. It sits behind the calculator's operation decoder and is started by a `comenzar` strobe; results are returned with a one-cycle `finalizado` pulse.

## Interface

- `WIDTH`, default 16: operand, quotient and remainder width in bits (legal range 4..32).

- `clock`  in  1: system clock. All logic is on the rising edge.
- `rst`  in  1: reset. One clock; reset is synchronous and active-high.
- `comenzar`  in  1: start request. Accepted only in `REPOSO`.
- `con_signo`  in  1: 1 selects two's-complement division, 0 selects unsigned. Sampled with the operands.
- `dividendo`  in  WIDTH: dividend. Sampled on the accept edge.
- `divisor`  in  WIDTH: divisor. Sampled on the accept edge.
- `ocupado`  out  1: high whenever the state is not `REPOSO`.
- `finalizado`  out  1: one-cycle pulse marking the cycle in which new results are valid.
- `cociente`  out  WIDTH: quotient.
- `residuo`  out  WIDTH: remainder.
- `div_cero`  out  1: the last result was a divide by zero.
- `desbordamiento`  out  1: the last result was a signed overflow (MIN / -1).

## Operation

- States: `REPOSO`, `CARGAR`, `ITERAR`, `CORREGIR`, `TERMINADO`.
- **REPOSO**
  - If `comenzar`=1: capture `dividendo`, `divisor` and `con_signo` into internal registers, then go to `CARGAR`.
  - Otherwise stay in `REPOSO`.
- **CARGAR**
  - Compute operand magnitudes; negate when `con_signo`=1 and the MSB is 1. The magnitude of MIN is 2^(WIDTH-1) and fits in WIDTH unsigned bits.
  - Record the quotient sign as XOR of the operand MSBs and the remainder sign as the dividend MSB. In unsigned mode both signs are 0.
  - Load the iteration counter with WIDTH.
  - If divisor == 0: write `cociente`=all ones, `residuo`=raw captured dividend, `div_cero`=1, `desbordamiento`=0, pulse `finalizado`, go to `TERMINADO`.
  - Otherwise go to `ITERAR`.
- **ITERAR** (one step per cycle, WIDTH cycles)
  - Shift the {partial remainder, dividend} pair left by one.
  - Form a trial subtraction in WIDTH+1 bits.
  - If the result is non-negative, commit it and set quotient bit = 1; otherwise restore and set quotient bit = 0.
  - Decrement the counter. When the counter reaches 0, go to `CORREGIR`.
- **CORREGIR**
  - Apply the signs: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Write `cociente` and `residuo`. Set `div_cero`=0. Set `desbordamiento`=1 only when `con_signo`=1, dividend=MIN and divisor=-1; in that case `cociente`=MIN (wrapped) and `residuo`=0.
  - Pulse `finalizado`, go to `TERMINADO`.
- **TERMINADO**
  - Drive `finalizado`=0, go to `REPOSO`. `comenzar` is ignored here.
- `comenzar` in any state other than `REPOSO` is ignored and is not queued.
- `cociente`, `residuo`, `div_cero` and `desbordamiento` hold their values until the next result write. They are not cleared when a new operation starts.
- Operand inputs may change freely after the accept edge.
- Unreachable state encodings recover to `REPOSO` on the next edge.

## Timing

- Edge 0 is the edge at which `comenzar` is sampled high in `REPOSO`; `ocupado` goes high after edge 0.
- Normal operation:
  - Edge 1: `CARGAR`.
  - Edges 2..WIDTH+1: `ITERAR`.
  - Edge WIDTH+2: `CORREGIR` writes results; `finalizado`=1 during the following cycle.
  - Edge WIDTH+3: `finalizado`=0; state and `ocupado` return to `REPOSO`/0.
  - For WIDTH=16: `finalizado` is high after edge 18, and the earliest next accept is edge 20.
- Divide by zero:
  - Results are written and `finalizado`=1 after edge 1.
  - Return to `REPOSO` after edge 2.
- Reset:
  - `rst`=1 at any edge (including mid-`ITERAR`) forces `REPOSO`.
  - All outputs are 0 after that edge: `cociente`, `residuo`, `finalizado`, `ocupado`, `div_cero`, `desbordamiento`.
  - `comenzar` is ignored while `rst`=1.
  - An aborted operation produces no `finalizado`.

## Test plan

- WIDTH=16, unsigned 100/7: `cociente`=14, `residuo`=2; `finalizado` pulses exactly one cycle, after edge 18; `ocupado` is high after edges 0..18.
- Signed -100/7 (0xFF9C/0x0007): `cociente`=0xFFF2 (-14), `residuo`=0xFFFE (-2). Signed 100/-7: `cociente`=0xFFF2, `residuo`=0x0002.
- Unsigned 0xFFFF/0x0001: `cociente`=0xFFFF, `residuo`=0. Unsigned 0x0003/0x0005: `cociente`=0, `residuo`=3. Also verify that the same 0xFFFF/0x0001 in signed mode yields `cociente`=0xFFFF (-1).
- Divide by zero, 1234/0: `cociente`=0xFFFF, `residuo`=0x04D2, `div_cero`=1, `finalizado` after edge 1. A following 10/3 run clears `div_cero` to 0 and gives `cociente`=3, `residuo`=1.
- Signed 0x8000/0xFFFF: `cociente`=0x8000, `residuo`=0, `desbordamiento`=1. A following signed 0x8000/0x0002 gives `cociente`=0xC000, `residuo`=0, `desbordamiento`=0.
- Busy and reset handling:
  - `comenzar` pulsed during `ITERAR` is ignored; the result and latency are unchanged.
  - `rst` asserted on the 8th `ITERAR` edge forces all outputs to 0 with no `finalizado`.
  - A new 50/5 accepted after reset gives `cociente`=10, `residuo`=0.
  - Repeat the 100/7 case at WIDTH=8 and WIDTH=32; `finalizado` follows after edges 10 and 34 respectively.
